jram_arbiter: RTL and testbench

//  Two-requester arbiter and strobe sequencer for the jRAM block.
//  It turns a req/ack transaction (read or write at an address) into the ordered jRAM strobes:

---
 rtl/jram_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_jram_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jram_arbiter.sv
// ---------------------------------------------------------------------------
// jram_arbiter
//   Two-requester round-robin arbiter and strobe sequencer for the jRAM block.
//   A granted transaction drives the jRAM strobes in order: address-set (sa),
//   one quiet gap cycle, then data-set (s) for a write or enable (e) for a
//   read. Each strobe is held SETTLE cycles, and a one-cycle ack goes back to
//   the owner. Only one transaction is in flight at a time.
//
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN      requester N transaction (N = 0 panel, 1 engine)
//   ackN                       one-cycle completion pulse to requester N
//   rdata                      data from the last completed read
//   busy                       high whenever a transaction is in flight
//   grant                      one-hot owner of the current transaction
//   ram_addr/ram_din           jRAM address and data buses
//   ram_sa/ram_s/ram_e         jRAM address-set, set and enable strobes
//   ram_dout                   jRAM read data
// ---------------------------------------------------------------------------
module jram_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int SETTLE = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [1:0]    grant,
    output logic [AW-1:0] ram_addr,
    output logic          ram_sa,
    output logic [DW-1:0] ram_din,
    output logic          ram_s,
    output logic          ram_e,
    input  logic [DW-1:0] ram_dout
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        GAP  = 3'd2,
        OP   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state_r, state_next_s;
    logic [CW-1:0] cnt_r, cnt_next_s;
    logic          owner_r, owner_next_s;   // 0 = requester 0, 1 = requester 1
    logic          last_r, last_next_s;     // owner of the previous grant
    logic          we_r, we_next_s;
    logic [AW-1:0] addr_r, addr_next_s;
    logic [DW-1:0] wdata_r, wdata_next_s;
    logic          win1_s;

    logic          ack0_next_s, ack1_next_s, busy_next_s;
    logic          ram_sa_next_s, ram_s_next_s, ram_e_next_s;
    logic [1:0]    grant_next_s;
    logic [AW-1:0] ram_addr_next_s;
    logic [DW-1:0] ram_din_next_s, rdata_next_s;

    // Next-state, arbitration and transaction latching.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        owner_next_s = owner_r;
        last_next_s  = last_r;
        we_next_s    = we_r;
        addr_next_s  = addr_r;
        wdata_next_s = wdata_r;
        win1_s       = 1'b0;
        case (state_r)
            IDLE: begin
                // Requester 1 wins alone, or on contention when 0 went last.
                win1_s = req1 & (~req0 | ~last_r);
                if (req0 | req1) begin
                    state_next_s = ADDR;
                    cnt_next_s   = CNT_LOAD;
                    owner_next_s = win1_s;
                    last_next_s  = win1_s;
                    if (win1_s) begin
                        we_next_s    = we1;
                        addr_next_s  = addr1;
                        wdata_next_s = wdata1;
                    end else begin
                        we_next_s    = we0;
                        addr_next_s  = addr0;
                        wdata_next_s = wdata0;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADDR: begin
                if (cnt_r == CNT_ONE) begin
                    state_next_s = GAP;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            GAP: begin
                state_next_s = OP;
                cnt_next_s   = CNT_LOAD;
            end
            OP: begin
                if (cnt_r == CNT_ONE) begin
                    state_next_s = DONE;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ONE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        busy_next_s   = (state_next_s != IDLE);
        ram_sa_next_s = (state_next_s == ADDR);
        ram_s_next_s  = (state_next_s == OP) & we_next_s;
        ram_e_next_s  = (state_next_s == OP) & ~we_next_s;
        ack0_next_s   = (state_next_s == DONE) & ~owner_next_s;
        ack1_next_s   = (state_next_s == DONE) & owner_next_s;
        if (state_next_s == IDLE) begin
            grant_next_s    = 2'b00;
            ram_addr_next_s = ram_addr;
        end else begin
            grant_next_s    = owner_next_s ? 2'b10 : 2'b01;
            ram_addr_next_s = addr_next_s;
        end
        if (ram_s_next_s) begin
            ram_din_next_s = wdata_next_s;
        end else begin
            ram_din_next_s = {DW{1'b0}};
        end
        // Capture read data on the edge that closes the last enable cycle.
        if ((state_r == OP) && !we_r && (cnt_r == CNT_ONE)) begin
            rdata_next_s = ram_dout;
        end else begin
            rdata_next_s = rdata;
        end
    end

    // State, latched transaction and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            owner_r  <= 1'b0;
            last_r   <= 1'b1;
            we_r     <= 1'b0;
            addr_r   <= {AW{1'b0}};
            wdata_r  <= {DW{1'b0}};
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
            grant    <= 2'b00;
            ram_addr <= {AW{1'b0}};
            ram_sa   <= 1'b0;
            ram_din  <= {DW{1'b0}};
            ram_s    <= 1'b0;
            ram_e    <= 1'b0;
            rdata    <= {DW{1'b0}};
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            owner_r  <= owner_next_s;
            last_r   <= last_next_s;
            we_r     <= we_next_s;
            addr_r   <= addr_next_s;
            wdata_r  <= wdata_next_s;
            ack0     <= ack0_next_s;
            ack1     <= ack1_next_s;
            busy     <= busy_next_s;
            grant    <= grant_next_s;
            ram_addr <= ram_addr_next_s;
            ram_sa   <= ram_sa_next_s;
            ram_din  <= ram_din_next_s;
            ram_s    <= ram_s_next_s;
            ram_e    <= ram_e_next_s;
            rdata    <= rdata_next_s;
        end
    end

endmodule

// File: tb/tb_jram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jram_arbiter
//   Directed bench for jram_arbiter with a behavioural jRAM, a table of
//   single transactions, hand-written multi-cycle sequences and a strobe
//   protocol monitor.
// ---------------------------------------------------------------------------
module tb_jram_arbiter;

    logic       CLK;
    logic       RESET;
    logic       req0, we0, ack0;
    logic [7:0] addr0, wdata0;
    logic       req1, we1, ack1;
    logic [7:0] addr1, wdata1;
    logic [7:0] rdata;
    logic       busy;
    logic [1:0] grant;
    logic [7:0] ram_addr, ram_din, ram_dout;
    logic       ram_sa, ram_s, ram_e;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem    [0:255];
    logic [7:0] shadow [0:255];

    jram_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .busy(busy), .grant(grant),
        .ram_addr(ram_addr), .ram_sa(ram_sa), .ram_din(ram_din),
        .ram_s(ram_s), .ram_e(ram_e), .ram_dout(ram_dout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural jRAM: output only valid while enabled.
    assign ram_dout = ram_e ? mem[ram_addr] : 8'h00;
    always @(posedge CLK) begin
        if (ram_s) mem[ram_addr] <= ram_din;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Protocol monitor.
    int         grants = 0;
    int         acks   = 0;
    logic       prev_any = 1'b0;
    logic [1:0] prev_grant = 2'b00;
    logic [7:0] prev_addr = 8'h00, prev_din = 8'h00;
    always @(negedge CLK) begin
        if (RESET) begin
            grants = acks;
            prev_any = 1'b0;
            prev_grant = 2'b00;
        end else begin
            if (ram_sa | ram_s | ram_e) begin
                chk("mon_strobe_excl", 32'($countones({ram_sa, ram_s, ram_e})), 32'd1);
                if (prev_any) begin
                    chk("mon_addr_stable", {24'd0, ram_addr}, {24'd0, prev_addr});
                    chk("mon_din_stable", {24'd0, ram_din}, {24'd0, prev_din});
                end
            end
            if (!ram_s) chk("mon_din_zero", {24'd0, ram_din}, 32'd0);
            if (grant != 2'b00 && prev_grant == 2'b00) grants++;
            if (ack0 | ack1) acks++;
            prev_any   = ram_sa | ram_s | ram_e;
            prev_grant = grant;
            prev_addr  = ram_addr;
            prev_din   = ram_din;
        end
    end

    // One complete transaction from an idle cycle, checking strobe timing,
    // grant, latency, ack routing and read data.
    task automatic do_txn(input int port, input logic we, input logic [7:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd, input string nm);
        int          lat;
        logic [31:0] sa_m, op_m, bad_m;
        logic [1:0]  g_seen, a_seen;
        lat = 0; sa_m = 32'd0; op_m = 32'd0; bad_m = 32'd0;
        g_seen = 2'b00; a_seen = 2'b00;
        @(posedge CLK); #1;
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
        end
        for (int n = 1; n <= 16 && lat == 0; n++) begin
            @(posedge CLK); #1;
            if (ram_sa) sa_m[n] = 1'b1;
            if (we ? ram_s : ram_e) op_m[n] = 1'b1;
            if (we ? ram_e : ram_s) bad_m[n] = 1'b1;
            if (n == 1) g_seen = grant;
            if (ack0 | ack1) begin
                lat = n;
                a_seen = {ack1, ack0};
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk({nm, "_latency"}, 32'(lat), 32'd6);
        chk({nm, "_sa_cycles"}, sa_m, 32'h0000_0006);
        chk({nm, "_op_cycles"}, op_m, 32'h0000_0030);
        chk({nm, "_wrong_strobe"}, bad_m, 32'd0);
        chk({nm, "_grant"}, {30'd0, g_seen}, (port == 0) ? 32'd1 : 32'd2);
        chk({nm, "_ack"}, {30'd0, a_seen}, (port == 0) ? 32'd1 : 32'd2);
        chk({nm, "_rdata"}, {24'd0, rdata}, {24'd0, exp_rd});
        if (we) shadow[addr] = wd;
    endtask

    typedef struct {
        int         port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int         lat;
        logic       seen;
        logic [1:0] g, a;
        logic [7:0] rd_model;
        int         port_r;
        logic       we_r;
        logic [7:0] addr_r, wd_r, exp_r;

        vecs[0] = '{0, 1'b1, 8'h05, 8'hA5, 8'h00};
        vecs[1] = '{0, 1'b0, 8'h05, 8'h00, 8'hA5};
        vecs[2] = '{1, 1'b1, 8'h10, 8'h3C, 8'hA5};
        vecs[3] = '{0, 1'b1, 8'h11, 8'hC3, 8'hA5};
        vecs[4] = '{0, 1'b0, 8'h10, 8'h00, 8'h3C};
        vecs[5] = '{1, 1'b0, 8'h11, 8'h00, 8'hC3};
        vecs[6] = '{1, 1'b0, 8'h20, 8'h00, 8'h11};
        vecs[7] = '{0, 1'b0, 8'h21, 8'h00, 8'h22};

        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            shadow[i] = 8'h00;
        end
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;

        // Reset values.
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_strobes", {29'd0, ram_sa, ram_s, ram_e}, 32'd0);
        chk("rst_busy_grant", {29'd0, busy, grant}, 32'd0);
        chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
        chk("rst_buses", {8'd0, ram_addr, ram_din, rdata}, 32'd0);
        RESET = 1'b0;

        // Contention straight after reset, both held for four transactions.
        @(posedge CLK); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h21; wdata1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            g = 2'b00; a = 2'b00; seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(posedge CLK); #1;
                if (g == 2'b00 && grant != 2'b00) g = grant;
                if (ack0 | ack1) begin
                    a = {ack1, ack0};
                    seen = 1'b1;
                end
            end
            chk($sformatf("contend_grant%0d", k), {30'd0, g}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("contend_ack%0d", k), {30'd0, a}, (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        req0 = 1'b0; req1 = 1'b0;
        shadow[8'h20] = 8'h11;
        shadow[8'h21] = 8'h22;
        chk("contend_rdata_unchanged", {24'd0, rdata}, 32'd0);

        // Table of single transactions.
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rd, $sformatf("vec%0d", i));
        end

        // Requester 1 drops its request during ADDR.
        @(posedge CLK); #1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10; wdata1 = 8'h00;
        @(posedge CLK); #1;
        chk("drop_in_addr", {31'd0, ram_sa}, 32'd1);
        req1 = 1'b0;
        lat = 0;
        for (int n = 2; n <= 16 && lat == 0; n++) begin
            @(posedge CLK); #1;
            if (ack1) lat = n;
        end
        chk("drop_latency", 32'(lat), 32'd6);
        chk("drop_rdata", {24'd0, rdata}, 32'h3C);
        seen = 1'b0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (busy | ack0 | ack1) seen = 1'b1;
        end
        chk("drop_no_second_txn", {31'd0, seen}, 32'd0);

        // Reset during the write OP phase.
        @(posedge CLK); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'h77;
        repeat (4) @(posedge CLK);
        #1;
        chk("midrst_in_op", {31'd0, ram_s}, 32'd1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("midrst_strobes", {29'd0, ram_sa, ram_s, ram_e}, 32'd0);
        chk("midrst_busy_grant", {29'd0, busy, grant}, 32'd0);
        chk("midrst_ack", {30'd0, ack1, ack0}, 32'd0);
        RESET = 1'b0;
        req0 = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge CLK); #1;
            if (ack0 | ack1) seen = 1'b1;
        end
        chk("midrst_no_ack", {31'd0, seen}, 32'd0);
        do_txn(0, 1'b1, 8'h31, 8'h55, 8'h00, "after_rst");

        // Random traffic on a fresh address window, checked against shadow.
        rd_model = 8'h00;
        for (int i = 0; i < 24; i++) begin
            port_r = int'($urandom_range(0, 1));
            we_r   = 1'($urandom_range(0, 1));
            addr_r = 8'h40 + 8'($urandom_range(0, 7));
            wd_r   = 8'($urandom_range(0, 255));
            exp_r  = we_r ? rd_model : shadow[addr_r];
            do_txn(port_r, we_r, addr_r, wd_r, exp_r, $sformatf("rand%0d", i));
            if (!we_r) rd_model = exp_r;
        end

        repeat (3) @(posedge CLK);
        #1;
        chk("mon_one_ack_per_grant", 32'(acks), 32'(grants));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
